// File: rtl/video_timing_pkg.sv
// Shared constants and flag bundle for the raster timing generator.
// Defaults describe 640x480@60 with a 4:1 pixel clock divider.
package video_timing_pkg;

  localparam int VGA_ACTIVE_COLUMNS     = 640;
  localparam int VGA_ACTIVE_ROWS        = 480;
  localparam int VGA_FRONT_PORCH_H      = 16;
  localparam int VGA_SYNC_H             = 96;
  localparam int VGA_BACK_PORCH_H       = 48;
  localparam int VGA_FRONT_PORCH_V      = 10;
  localparam int VGA_SYNC_V             = 2;
  localparam int VGA_BACK_PORCH_V       = 33;
  localparam int VGA_HSYNC_ACTIVE_LOW   = 1;
  localparam int VGA_VSYNC_ACTIVE_LOW   = 1;
  localparam int VGA_CLK_DIV            = 4;
  localparam int VGA_PIPELINE_DELAY     = 2;

  typedef struct packed {
    logic hs;
    logic vs;
    logic active;
    logic ls;
    logic fs;
  } sync_flags_t;

endpackage

// File: rtl/sync_delay_line.sv
// Tick-enabled shift register used to align sync flags with pixel data.
// A depth of zero degenerates into a plain wire.
module sync_delay_line #(
  parameter int  DEPTH = 2,
  parameter type T     = logic
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic tick_i,
  input  T     d_i,
  output T     q_o
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ok;
    assign unused_ok = clk_i ^ reset_i ^ tick_i;
    assign q_o = d_i;
  end else begin : g_shift
    T stage_q [DEPTH];

    // shift one stage per pixel tick, cleared on reset
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= '0;
        end
      end else if (tick_i) begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/video_timing_generator.sv
// Raster timing generator: pixel divider, x/y/linear counters and
// delayed sync/blank/strobe outputs aligned to framebuffer reads.
module video_timing_generator
  import video_timing_pkg::*;
#(
  parameter int ACTIVE_COLUMNS         = VGA_ACTIVE_COLUMNS,
  parameter int ACTIVE_ROWS            = VGA_ACTIVE_ROWS,
  parameter int FRONT_PORCH_HORIZONTAL = VGA_FRONT_PORCH_H,
  parameter int SYNC_HORIZONTAL        = VGA_SYNC_H,
  parameter int BACK_PORCH_HORIZONTAL  = VGA_BACK_PORCH_H,
  parameter int FRONT_PORCH_VERTICAL   = VGA_FRONT_PORCH_V,
  parameter int SYNC_VERTICAL          = VGA_SYNC_V,
  parameter int BACK_PORCH_VERTICAL    = VGA_BACK_PORCH_V,
  parameter int HSYNC_ACTIVE_LOW       = VGA_HSYNC_ACTIVE_LOW,
  parameter int VSYNC_ACTIVE_LOW       = VGA_VSYNC_ACTIVE_LOW,
  parameter int CLK_DIV                = VGA_CLK_DIV,
  parameter int PIPELINE_DELAY         = VGA_PIPELINE_DELAY,
  localparam int TOTAL_COLUMNS = ACTIVE_COLUMNS + FRONT_PORCH_HORIZONTAL
                               + SYNC_HORIZONTAL + BACK_PORCH_HORIZONTAL,
  localparam int TOTAL_ROWS    = ACTIVE_ROWS + FRONT_PORCH_VERTICAL
                               + SYNC_VERTICAL + BACK_PORCH_VERTICAL,
  localparam int XW = $clog2(TOTAL_COLUMNS),
  localparam int YW = $clog2(TOTAL_ROWS),
  localparam int PW = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS) + 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  output logic          pix_tick_o,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic [PW-1:0] pixel_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          video_en_o,
  output logic          line_start_o,
  output logic          frame_start_o,
  output logic          vblank_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  // range bounds carry one spare bit so an end equal to 2**XW still fits
  localparam logic [XW-1:0] X_LAST = XW'(TOTAL_COLUMNS - 1);
  localparam logic [XW:0]   X_AC   = (XW+1)'(ACTIVE_COLUMNS);
  localparam logic [XW:0]   X_HS0  =
    (XW+1)'(ACTIVE_COLUMNS + FRONT_PORCH_HORIZONTAL);
  localparam logic [XW:0]   X_HS1  =
    (XW+1)'(ACTIVE_COLUMNS + FRONT_PORCH_HORIZONTAL + SYNC_HORIZONTAL);

  localparam logic [YW-1:0] Y_LAST = YW'(TOTAL_ROWS - 1);
  localparam logic [YW:0]   Y_AR   = (YW+1)'(ACTIVE_ROWS);
  localparam logic [YW:0]   Y_VS0  =
    (YW+1)'(ACTIVE_ROWS + FRONT_PORCH_VERTICAL);
  localparam logic [YW:0]   Y_VS1  =
    (YW+1)'(ACTIVE_ROWS + FRONT_PORCH_VERTICAL + SYNC_VERTICAL);

  localparam logic HS_POL = (HSYNC_ACTIVE_LOW != 0);
  localparam logic VS_POL = (VSYNC_ACTIVE_LOW != 0);

  logic [DW-1:0] div_q, div_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [PW-1:0] pixel_q, pixel_d;
  logic          tick;
  logic          wrap_x;
  logic          wrap_frame;
  sync_flags_t   raw_f;
  sync_flags_t   dly_f;
  sync_flags_t   out_f;

  assign tick       = (div_q == DIV_LAST);
  assign wrap_x     = (x_q == X_LAST);
  assign wrap_frame = wrap_x && (y_q == Y_LAST);

  // raw flags decoded from the current undelayed position
  always_comb begin
    raw_f        = '0;
    raw_f.active = ({1'b0, x_q} < X_AC) && ({1'b0, y_q} < Y_AR);
    raw_f.hs     = ({1'b0, x_q} >= X_HS0) && ({1'b0, x_q} < X_HS1);
    raw_f.vs     = ({1'b0, y_q} >= Y_VS0) && ({1'b0, y_q} < Y_VS1);
    raw_f.ls     = (x_q == '0);
    raw_f.fs     = (x_q == '0) && (y_q == '0);
  end

  // next-state for divider and raster counters
  always_comb begin
    div_d   = tick ? '0 : div_q + DW'(1);
    x_d     = x_q;
    y_d     = y_q;
    pixel_d = pixel_q;
    if (tick) begin
      if (wrap_x) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
      if (wrap_frame) begin
        pixel_d = '0;
      end else if (raw_f.active) begin
        pixel_d = pixel_q + PW'(1);
      end
    end
  end

  // divider and counter state
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      div_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      pixel_q <= '0;
    end else begin
      div_q   <= div_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pixel_q <= pixel_d;
    end
  end

  sync_delay_line #(
    .DEPTH (PIPELINE_DELAY),
    .T     (sync_flags_t)
  ) u_delay (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .tick_i  (tick),
    .d_i     (raw_f),
    .q_o     (dly_f)
  );

  // masking by reset keeps the zero-depth path at its idle level too
  assign out_f = reset_i ? '0 : dly_f;

  assign pix_tick_o    = tick & ~reset_i;
  assign x_o           = x_q;
  assign y_o           = y_q;
  assign pixel_o       = pixel_q;
  assign hsync_o       = out_f.hs ^ HS_POL;
  assign vsync_o       = out_f.vs ^ VS_POL;
  assign video_en_o    = out_f.active;
  assign line_start_o  = out_f.ls & pix_tick_o;
  assign frame_start_o = out_f.fs & pix_tick_o;
  assign vblank_o      = ({1'b0, y_q} >= Y_AR);

endmodule

// File: tb/tb_video_timing_generator.sv
// Bench for video_timing_generator: three small-geometry instances
// against an arithmetic raster model, vector tables and reset sequences.
module tb_video_timing_generator;

  typedef struct {
    int ac; int ar; int fph; int sh; int bph;
    int fpv; int sv; int bpv;
    int hlow; int vlow; int div; int dly;
  } cfg_t;

  typedef struct {
    int tick; int x; int y; int pix;
    int hs; int vs; int ven; int ls; int fs; int vb;
  } exp_t;

  typedef struct {
    int   n;
    int   d;
    exp_t e;
  } vec_t;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk = ~clk;

  logic       tk0, hs0, vs0, ven0, ls0, fs0, vb0;
  logic [3:0] x0;
  logic [2:0] y0;
  logic [5:0] p0;
  logic       tk1, hs1, vs1, ven1, ls1, fs1, vb1;
  logic [3:0] x1;
  logic [2:0] y1;
  logic [5:0] p1;
  logic       tk2, hs2, vs2, ven2, ls2, fs2, vb2;
  logic [3:0] x2;
  logic [2:0] y2;
  logic [5:0] p2;

  video_timing_generator #(
    .ACTIVE_COLUMNS(8), .ACTIVE_ROWS(4),
    .FRONT_PORCH_HORIZONTAL(2), .SYNC_HORIZONTAL(3),
    .BACK_PORCH_HORIZONTAL(1),
    .FRONT_PORCH_VERTICAL(1), .SYNC_VERTICAL(1),
    .BACK_PORCH_VERTICAL(1),
    .HSYNC_ACTIVE_LOW(1), .VSYNC_ACTIVE_LOW(1),
    .CLK_DIV(2), .PIPELINE_DELAY(0)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .pix_tick_o(tk0),
    .x_o(x0), .y_o(y0), .pixel_o(p0),
    .hsync_o(hs0), .vsync_o(vs0), .video_en_o(ven0),
    .line_start_o(ls0), .frame_start_o(fs0), .vblank_o(vb0)
  );

  video_timing_generator #(
    .ACTIVE_COLUMNS(8), .ACTIVE_ROWS(4),
    .FRONT_PORCH_HORIZONTAL(2), .SYNC_HORIZONTAL(3),
    .BACK_PORCH_HORIZONTAL(1),
    .FRONT_PORCH_VERTICAL(1), .SYNC_VERTICAL(1),
    .BACK_PORCH_VERTICAL(1),
    .HSYNC_ACTIVE_LOW(1), .VSYNC_ACTIVE_LOW(1),
    .CLK_DIV(2), .PIPELINE_DELAY(2)
  ) dut_d2 (
    .clk_i(clk), .reset_i(reset_i), .pix_tick_o(tk1),
    .x_o(x1), .y_o(y1), .pixel_o(p1),
    .hsync_o(hs1), .vsync_o(vs1), .video_en_o(ven1),
    .line_start_o(ls1), .frame_start_o(fs1), .vblank_o(vb1)
  );

  video_timing_generator #(
    .ACTIVE_COLUMNS(8), .ACTIVE_ROWS(4),
    .FRONT_PORCH_HORIZONTAL(2), .SYNC_HORIZONTAL(3),
    .BACK_PORCH_HORIZONTAL(1),
    .FRONT_PORCH_VERTICAL(1), .SYNC_VERTICAL(1),
    .BACK_PORCH_VERTICAL(1),
    .HSYNC_ACTIVE_LOW(0), .VSYNC_ACTIVE_LOW(1),
    .CLK_DIV(1), .PIPELINE_DELAY(0)
  ) dut_c1 (
    .clk_i(clk), .reset_i(reset_i), .pix_tick_o(tk2),
    .x_o(x2), .y_o(y2), .pixel_o(p2),
    .hsync_o(hs2), .vsync_o(vs2), .video_en_o(ven2),
    .line_start_o(ls2), .frame_start_o(fs2), .vblank_o(vb2)
  );

  int   total = 0;
  int   bad = 0;
  int   n = 0;
  cfg_t cfgs [3];
  vec_t tbl [$];

  task automatic cmp(string name, int got, int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (n=%0d)",
               name, got, want, n);
    end
  endtask

  // position after t ticks, then flags/outputs by plain arithmetic
  function automatic exp_t model(cfg_t c, int cyc);
    exp_t e;
    int tc, tr, fr, ticks, p, x, y, q, dx, dy;
    int hs, vs, act, ls, fs;
    tc = c.ac + c.fph + c.sh + c.bph;
    tr = c.ar + c.fpv + c.sv + c.bpv;
    fr = tc * tr;
    ticks = cyc / c.div;
    p = ticks % fr;
    x = p % tc;
    y = p / tc;
    e.tick = ((cyc % c.div) == c.div - 1) ? 1 : 0;
    e.x = x;
    e.y = y;
    if (y >= c.ar) e.pix = c.ac * c.ar;
    else if (x >= c.ac) e.pix = (y + 1) * c.ac;
    else e.pix = y * c.ac + x;
    e.vb = (y >= c.ar) ? 1 : 0;
    hs = 0; vs = 0; act = 0; ls = 0; fs = 0;
    if (ticks >= c.dly) begin
      q = (ticks - c.dly) % fr;
      dx = q % tc;
      dy = q / tc;
      act = (dx < c.ac && dy < c.ar) ? 1 : 0;
      hs = (dx >= c.ac + c.fph && dx < c.ac + c.fph + c.sh) ? 1 : 0;
      vs = (dy >= c.ar + c.fpv && dy < c.ar + c.fpv + c.sv) ? 1 : 0;
      ls = (dx == 0) ? 1 : 0;
      fs = (dx == 0 && dy == 0) ? 1 : 0;
    end
    e.hs  = hs ^ c.hlow;
    e.vs  = vs ^ c.vlow;
    e.ven = act;
    e.ls  = ls & e.tick;
    e.fs  = fs & e.tick;
    return e;
  endfunction

  function automatic exp_t model_reset(cfg_t c);
    exp_t e;
    e.tick = 0; e.x = 0; e.y = 0; e.pix = 0;
    e.hs = c.hlow; e.vs = c.vlow;
    e.ven = 0; e.ls = 0; e.fs = 0; e.vb = 0;
    return e;
  endfunction

  function automatic exp_t actual(int i);
    exp_t g;
    g = '{default: 0};
    case (i)
      0: g = '{int'(tk0), int'(x0), int'(y0), int'(p0), int'(hs0),
               int'(vs0), int'(ven0), int'(ls0), int'(fs0), int'(vb0)};
      1: g = '{int'(tk1), int'(x1), int'(y1), int'(p1), int'(hs1),
               int'(vs1), int'(ven1), int'(ls1), int'(fs1), int'(vb1)};
      default:
         g = '{int'(tk2), int'(x2), int'(y2), int'(p2), int'(hs2),
               int'(vs2), int'(ven2), int'(ls2), int'(fs2), int'(vb2)};
    endcase
    return g;
  endfunction

  task automatic check_vec(int i, exp_t w, string tag);
    exp_t g;
    g = actual(i);
    cmp($sformatf("%s d%0d tick", tag, i), g.tick, w.tick);
    cmp($sformatf("%s d%0d x", tag, i), g.x, w.x);
    cmp($sformatf("%s d%0d y", tag, i), g.y, w.y);
    cmp($sformatf("%s d%0d pixel", tag, i), g.pix, w.pix);
    cmp($sformatf("%s d%0d hsync", tag, i), g.hs, w.hs);
    cmp($sformatf("%s d%0d vsync", tag, i), g.vs, w.vs);
    cmp($sformatf("%s d%0d video_en", tag, i), g.ven, w.ven);
    cmp($sformatf("%s d%0d line_start", tag, i), g.ls, w.ls);
    cmp($sformatf("%s d%0d frame_start", tag, i), g.fs, w.fs);
    cmp($sformatf("%s d%0d vblank", tag, i), g.vb, w.vb);
  endtask

  task automatic check_model();
    for (int i = 0; i < 3; i++) check_vec(i, model(cfgs[i], n), "model");
  endtask

  task automatic check_reset();
    for (int i = 0; i < 3; i++) check_vec(i, model_reset(cfgs[i]), "reset");
  endtask

  task automatic step();
    @(posedge clk);
    n++;
    @(negedge clk);
    check_model();
  endtask

  // called at a falling edge: assert now, hold, release at a falling edge
  task automatic do_reset(int cyc);
    reset_i = 1'b1;
    #1;
    check_reset();
    repeat (cyc) begin
      @(posedge clk);
      @(negedge clk);
      check_reset();
    end
    reset_i = 1'b0;
    n = 0;
    #1;
    check_model();
  endtask

  function automatic vec_t mk(int cyc, int d, int tick, int x, int y,
                              int pix, int hs, int vs, int ven, int ls,
                              int fs, int vb);
    vec_t v;
    v.n = cyc;
    v.d = d;
    v.e = '{tick, x, y, pix, hs, vs, ven, ls, fs, vb};
    return v;
  endfunction

  int hs_low_line, ven_line, fs_frame, hs_hi_c1;

  initial begin
    cfgs[0] = '{8, 4, 2, 3, 1, 1, 1, 1, 1, 1, 2, 0};
    cfgs[1] = '{8, 4, 2, 3, 1, 1, 1, 1, 1, 1, 2, 2};
    cfgs[2] = '{8, 4, 2, 3, 1, 1, 1, 1, 0, 1, 1, 0};

    //            n   d tk  x  y pix hs vs en ls fs vb
    tbl.push_back(mk(0,   0, 0, 0, 0, 0,  1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1,   0, 1, 0, 0, 0,  1, 1, 1, 1, 1, 0));
    tbl.push_back(mk(2,   0, 0, 1, 0, 1,  1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(20,  0, 0, 10, 0, 8, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(25,  0, 1, 12, 0, 8, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(26,  0, 0, 13, 0, 8, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(28,  0, 0, 0, 1, 8,  1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(29,  0, 1, 0, 1, 8,  1, 1, 1, 1, 0, 0));
    tbl.push_back(mk(114, 0, 0, 1, 4, 32, 1, 1, 0, 0, 0, 1));
    tbl.push_back(mk(140, 0, 0, 0, 5, 32, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(167, 0, 1, 13, 5, 32, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(168, 0, 0, 0, 6, 32, 1, 1, 0, 0, 0, 1));
    tbl.push_back(mk(196, 0, 0, 0, 0, 0,  1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(197, 0, 1, 0, 0, 0,  1, 1, 1, 1, 1, 0));
    tbl.push_back(mk(3,   1, 1, 1, 0, 1,  1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(5,   1, 1, 2, 0, 2,  1, 1, 1, 1, 1, 0));
    tbl.push_back(mk(24,  1, 0, 12, 0, 8, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(29,  1, 1, 0, 1, 8,  0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(32,  1, 0, 2, 1, 10, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(10,  2, 1, 10, 0, 8, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(13,  2, 1, 13, 0, 8, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(14,  2, 1, 0, 1, 8,  0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(98,  2, 1, 0, 0, 0,  0, 1, 1, 1, 1, 0));

    // held in reset across a few edges
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check_reset();
    end

    // release, then one full frame plus a few cycles with tables
    reset_i = 1'b0;
    n = 0;
    #1;
    hs_low_line = 0; ven_line = 0; fs_frame = 0; hs_hi_c1 = 0;
    for (int k = 0; k <= 200; k++) begin
      if (k > 0) step();
      else check_model();
      foreach (tbl[j]) begin
        if (tbl[j].n == n) check_vec(tbl[j].d, tbl[j].e, "table");
      end
      if (n < 28) begin
        if (hs0 == 1'b0) hs_low_line++;
        if (ven0 == 1'b1) ven_line++;
      end
      if (n < 196 && fs0 == 1'b1) fs_frame++;
      if (n < 14 && hs2 == 1'b1) hs_hi_c1++;
    end
    cmp("line hsync low clocks", hs_low_line, 6);
    cmp("line video_en clocks", ven_line, 16);
    cmp("frame_start per frame", fs_frame, 1);
    cmp("c1 hsync high clocks", hs_hi_c1, 3);

    // mid-line reset at x=5, y=2 of the divide-by-2 instance
    @(negedge clk);
    do_reset(1);
    repeat (66) step();
    cmp("midline x", int'(x0), 5);
    cmp("midline y", int'(y0), 2);
    do_reset(1);
    repeat (40) step();

    // random run lengths and reset pulses
    for (int r = 0; r < 8; r++) begin
      int len;
      len = $urandom_range(1, 400);
      repeat (len) step();
      do_reset($urandom_range(0, 3));
    end
    repeat (50) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
